// File: rtl/crp16_exec_stage_pkg.sv
// Shared CRP16 definitions: ALU select codes, flag bit positions and the E1 operation record.
// Both the execute stage and its ALU import this package so the encodings live in one place.
package crp16_exec_stage_pkg;

   localparam int unsigned FLAG_V = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_Z = 0;

   // Select codes 0xx0 = add and 0xx1 = sub are decoded from bits 3 and 0 only.
   localparam logic [3:0] SEL_ADD = 4'b0000;
   localparam logic [3:0] SEL_SUB = 4'b0001;
   localparam logic [3:0] SEL_SHL = 4'b1000;
   localparam logic [3:0] SEL_LSR = 4'b1010;
   localparam logic [3:0] SEL_ASR = 4'b1011;
   localparam logic [3:0] SEL_AND = 4'b1100;
   localparam logic [3:0] SEL_OR  = 4'b1101;
   localparam logic [3:0] SEL_NOT = 4'b1110;
   localparam logic [3:0] SEL_XOR = 4'b1111;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [3:0]  sel;
      logic [2:0]  dest;
      logic        write;
      logic        set_flags;
   } e1_op_t;

   function automatic logic is_arith(input logic [3:0] sel);
      return ~sel[3];
   endfunction

endpackage

// File: rtl/crp16_alu.sv
// Combinational CRP16 ALU. Produces the result and a candidate {v,c,n,z}; the caller decides which bits load.
// Subtraction is x + ~y + 1, so c is the carry out (1 = no borrow).
module crp16_alu
   import crp16_exec_stage_pkg::*;
(
   input  logic [15:0] x_i,
   input  logic [15:0] y_i,
   input  logic [3:0]  sel_i,
   output logic [15:0] result_o,
   output logic [3:0]  flags_o
);

   logic [15:0] y_eff;
   logic [16:0] sum;
   logic [3:0]  shamt;

   assign y_eff = sel_i[0] ? ~y_i : y_i;
   assign sum   = {1'b0, x_i} + {1'b0, y_eff} + {16'd0, sel_i[0]};
   assign shamt = y_i[3:0];

   always_comb begin
      result_o = sum[15:0];
      if (sel_i[3]) begin
         case (sel_i[2:0])
            3'b000, 3'b001: result_o = x_i << shamt;
            3'b010:         result_o = x_i >> shamt;
            3'b011:         result_o = $unsigned($signed(x_i) >>> shamt);
            3'b100:         result_o = x_i & y_i;
            3'b101:         result_o = x_i | y_i;
            3'b110:         result_o = ~x_i;
            default:        result_o = x_i ^ y_i;
         endcase
      end
   end

   always_comb begin
      flags_o         = '0;
      flags_o[FLAG_V] = (x_i[15] == y_eff[15]) && (sum[15] != x_i[15]);
      flags_o[FLAG_C] = sum[16];
      flags_o[FLAG_N] = result_o[15];
      flags_o[FLAG_Z] = (result_o == 16'd0);
   end

endmodule

// File: rtl/crp16_exec_stage.sv
// CRP16 execute stage: E1 operand register -> ALU -> E2 result register with valid/ready handshakes.
// Flags load alongside E2 so they become visible in the same cycle as the result.
module crp16_exec_stage
   import crp16_exec_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_x,
   input  logic [15:0] in_y,
   input  logic [3:0]  in_select,
   input  logic [2:0]  in_dest,
   input  logic        in_write,
   input  logic        in_set_flags,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic [2:0]  out_dest,
   output logic        out_write,
   output logic [3:0]  flags
);

   e1_op_t      e1_q, e1_d;
   logic        e1_valid_q, e1_valid_d;
   logic        e2_valid_q, e2_valid_d;
   logic [15:0] e2_result_q, e2_result_d;
   logic [2:0]  e2_dest_q, e2_dest_d;
   logic        e2_write_q, e2_write_d;
   logic [3:0]  flags_q, flags_d;

   logic [15:0] alu_result;
   logic [3:0]  alu_flags;
   logic        e1_adv;
   logic        accept;
   logic        e2_pop;

   crp16_alu u_alu (
      .x_i      (e1_q.x),
      .y_i      (e1_q.y),
      .sel_i    (e1_q.sel),
      .result_o (alu_result),
      .flags_o  (alu_flags)
   );

   assign e1_adv   = e1_valid_q & (~e2_valid_q | out_ready);
   assign in_ready = ~reset & ~flush & (~e1_valid_q | e1_adv);
   assign accept   = in_valid & in_ready;
   assign e2_pop   = e2_valid_q & out_ready;

   always_comb begin
      e1_d        = e1_q;
      e1_valid_d  = e1_valid_q;
      e2_valid_d  = e2_valid_q;
      e2_result_d = e2_result_q;
      e2_dest_d   = e2_dest_q;
      e2_write_d  = e2_write_q;
      flags_d     = flags_q;
      if (flush) begin
         // Flush drops both stages and suppresses the flag update of the E1 operation.
         e1_valid_d = 1'b0;
         e2_valid_d = 1'b0;
      end else begin
         if (e2_pop)
            e2_valid_d = 1'b0;
         if (e1_adv) begin
            e2_valid_d  = 1'b1;
            e2_result_d = alu_result;
            e2_dest_d   = e1_q.dest;
            e2_write_d  = e1_q.write;
            e1_valid_d  = 1'b0;
            if (e1_q.set_flags) begin
               flags_d[FLAG_N] = alu_flags[FLAG_N];
               flags_d[FLAG_Z] = alu_flags[FLAG_Z];
               if (is_arith(e1_q.sel)) begin
                  flags_d[FLAG_V] = alu_flags[FLAG_V];
                  flags_d[FLAG_C] = alu_flags[FLAG_C];
               end
            end
         end
         if (accept) begin
            e1_valid_d     = 1'b1;
            e1_d.x         = in_x;
            e1_d.y         = in_y;
            e1_d.sel       = in_select;
            e1_d.dest      = in_dest;
            e1_d.write     = in_write;
            e1_d.set_flags = in_set_flags;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         e1_q        <= '0;
         e1_valid_q  <= 1'b0;
         e2_valid_q  <= 1'b0;
         e2_result_q <= '0;
         e2_dest_q   <= '0;
         e2_write_q  <= 1'b0;
         flags_q     <= '0;
      end else begin
         e1_q        <= e1_d;
         e1_valid_q  <= e1_valid_d;
         e2_valid_q  <= e2_valid_d;
         e2_result_q <= e2_result_d;
         e2_dest_q   <= e2_dest_d;
         e2_write_q  <= e2_write_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid  = e2_valid_q;
   assign out_result = e2_result_q;
   assign out_dest   = e2_dest_q;
   assign out_write  = e2_valid_q & e2_write_q;
   assign flags      = flags_q;

endmodule

// File: tb/tb_crp16_exec_stage.sv
// Directed bench for crp16_exec_stage: reset, flag updates, back-to-back ops, stall, flush and reset-while-full.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_crp16_exec_stage;

   logic        clock = 1'b0;
   logic        reset, in_valid, in_ready, in_write, in_set_flags, flush;
   logic        out_valid, out_ready, out_write;
   logic [15:0] in_x, in_y, out_result;
   logic [3:0]  in_select, flags;
   logic [2:0]  in_dest, out_dest;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   crp16_exec_stage dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_x         (in_x),
      .in_y         (in_y),
      .in_select    (in_select),
      .in_dest      (in_dest),
      .in_write     (in_write),
      .in_set_flags (in_set_flags),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_dest     (out_dest),
      .out_write    (out_write),
      .flags        (flags)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_op(input logic [15:0] x, input logic [15:0] y, input logic [3:0] sel,
                           input logic [2:0] dest, input logic wr, input logic sf);
      in_valid = 1'b1; in_x = x; in_y = y; in_select = sel;
      in_dest = dest; in_write = wr; in_set_flags = sf;
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_x = '0; in_y = '0; in_select = '0; in_dest = '0; in_write = 1'b0; in_set_flags = 1'b0;
      step(); step();
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", flags); end
      vectors++; if (out_result !== 16'h0000 || out_dest !== 3'd0 || out_write !== 1'b0) begin
         miscompares++; $display("FAIL reset_outputs: got %h/%0d/%b want 0000/0/0", out_result, out_dest, out_write); end
      reset = 1'b0; #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add_flags();
      drive_op(16'h7FFF, 16'h0001, 4'b0000, 3'd3, 1'b1, 1'b1);
      step(); idle();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_early: got out_valid %b want 0", out_valid); end
      step();
      $display("add 7fff+0001 -> %h dest %0d flags %b", out_result, out_dest, flags);
      vectors++; if (out_valid !== 1'b1 || out_result !== 16'h8000) begin
         miscompares++; $display("FAIL add_result: got %b/%h want 1/8000", out_valid, out_result); end
      vectors++; if (out_dest !== 3'd3 || out_write !== 1'b1) begin
         miscompares++; $display("FAIL add_dest: got %0d/%b want 3/1", out_dest, out_write); end
      vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL add_flags: got %b want 1010", flags); end
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got out_valid %b want 0", out_valid); end
   endtask

   task automatic test_and_retain();
      drive_op(16'h0F0F, 16'h00FF, 4'b1100, 3'd5, 1'b0, 1'b1);
      step(); idle(); step();
      $display("and 0f0f&00ff -> %h flags %b", out_result, flags);
      vectors++; if (out_result !== 16'h000F) begin miscompares++; $display("FAIL and_result: got %h want 000f", out_result); end
      vectors++; if (flags !== 4'b1000) begin miscompares++; $display("FAIL and_flags: got %b want 1000", flags); end
      vectors++; if (out_write !== 1'b0 || out_dest !== 3'd5) begin
         miscompares++; $display("FAIL and_ctrl: got %b/%0d want 0/5", out_write, out_dest); end
      step();
   endtask

   task automatic test_sub_zero();
      drive_op(16'h0005, 16'h0005, 4'b0001, 3'd1, 1'b1, 1'b1);
      step(); idle(); step();
      $display("sub 0005-0005 -> %h flags %b", out_result, flags);
      vectors++; if (out_result !== 16'h0000) begin miscompares++; $display("FAIL sub_result: got %h want 0000", out_result); end
      vectors++; if (flags[3] !== 1'b0 || flags[1] !== 1'b0 || flags[0] !== 1'b1) begin
         miscompares++; $display("FAIL sub_vnz: got v%b n%b z%b want v0 n0 z1", flags[3], flags[1], flags[0]); end
      step();
      // ffff + 0001 wraps to zero with carry out: v0 c1 n0 z1
      drive_op(16'hFFFF, 16'h0001, 4'b0000, 3'd2, 1'b1, 1'b1);
      step(); idle(); step();
      vectors++; if (out_result !== 16'h0000 || flags !== 4'b0101) begin
         miscompares++; $display("FAIL add_wrap: got %h/%b want 0000/0101", out_result, flags); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [15:0] xs  [9] = '{16'h0001, 16'h8000, 16'h8000, 16'h00F0, 16'h1234, 16'hFFFF, 16'h0003, 16'h0002, 16'h0010};
      logic [15:0] ys  [9] = '{16'h0004, 16'h000F, 16'h0004, 16'h0F00, 16'h0000, 16'h0F0F, 16'h0001, 16'h0003, 16'h0001};
      logic [3:0]  sels[9] = '{4'b1000, 4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b1001, 4'b0110, 4'b0111};
      logic [15:0] exps[9] = '{16'h0010, 16'h0001, 16'hF800, 16'h0FF0, 16'hEDCB, 16'hF0F0, 16'h0006, 16'h0005, 16'h000F};
      out_ready = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         if (i < 9) drive_op(xs[i], ys[i], sels[i], 3'(i), 1'b1, 1'b0);
         else idle();
         if (i < 9) begin
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
         end
         step();
         if (i >= 1) begin
            $display("b2b op %0d sel %b -> %h dest %0d", i - 1, sels[i-1], out_result, out_dest);
            vectors++; if (out_valid !== 1'b1 || out_result !== exps[i-1] || out_dest !== 3'(i - 1)) begin
               miscompares++; $display("FAIL b2b_result[%0d]: got %b/%h/%0d want 1/%h/%0d",
                                       i - 1, out_valid, out_result, out_dest, exps[i-1], i - 1); end
         end
      end
      vectors++; if (flags !== 4'b0101) begin miscompares++; $display("FAIL b2b_flags_kept: got %b want 0101", flags); end
      step();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      drive_op(16'h0001, 16'h0001, 4'b0000, 3'd1, 1'b1, 1'b0);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_a: got %b want 1", in_ready); end
      step();
      drive_op(16'h0002, 16'h0002, 4'b0000, 3'd2, 1'b1, 1'b0);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_b: got %b want 1", in_ready); end
      step();
      drive_op(16'h0003, 16'h0003, 4'b0000, 3'd3, 1'b1, 1'b0);
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_c: got %b want 0", in_ready); end
      step(); #1;
      vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 16'h0002) begin
         miscompares++; $display("FAIL stall_hold: got rdy %b vld %b res %h want 0/1/0002", in_ready, out_valid, out_result); end
      out_ready = 1'b1; #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
      step(); idle();
      $display("stall release -> %h dest %0d", out_result, out_dest);
      vectors++; if (out_valid !== 1'b1 || out_result !== 16'h0004 || out_dest !== 3'd2) begin
         miscompares++; $display("FAIL stall_second: got %b/%h/%0d want 1/0004/2", out_valid, out_result, out_dest); end
      step();
      $display("stall release -> %h dest %0d", out_result, out_dest);
      vectors++; if (out_valid !== 1'b1 || out_result !== 16'h0006 || out_dest !== 3'd3) begin
         miscompares++; $display("FAIL stall_third: got %b/%h/%0d want 1/0006/3", out_valid, out_result, out_dest); end
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive_op(16'h1111, 16'h0001, 4'b0000, 3'd4, 1'b1, 1'b0);
      step();
      drive_op(16'hFFFF, 16'h8000, 4'b1100, 3'd5, 1'b1, 1'b1);
      step();
      drive_op(16'h0007, 16'h0001, 4'b0000, 3'd6, 1'b1, 1'b1);
      flush = 1'b1; out_ready = 1'b1; #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", in_ready); end
      step();
      flush = 1'b0; idle();
      vectors++; if (out_valid !== 1'b0 || out_write !== 1'b0) begin
         miscompares++; $display("FAIL flush_out_valid: got %b/%b want 0/0", out_valid, out_write); end
      vectors++; if (flags !== 4'b0101) begin miscompares++; $display("FAIL flush_flags: got %b want 0101", flags); end
      step(); step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_input_dropped: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      drive_op(16'h00AA, 16'h0001, 4'b0000, 3'd7, 1'b1, 1'b1);
      step();
      drive_op(16'h00BB, 16'h0001, 4'b0000, 3'd6, 1'b1, 1'b1);
      step();
      vectors++; if (out_valid !== 1'b1 || out_result !== 16'h00AB) begin
         miscompares++; $display("FAIL rstfull_setup: got %b/%h want 1/00ab", out_valid, out_result); end
      reset = 1'b1; #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstfull_ready: got %b want 0", in_ready); end
      step();
      vectors++; if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_dest !== 3'd0 || out_write !== 1'b0 || flags !== 4'b0000) begin
         miscompares++; $display("FAIL rstfull_outputs: got %b/%h/%0d/%b/%b want all 0",
                                 out_valid, out_result, out_dest, out_write, flags); end
      reset = 1'b0; idle();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstfull_release: got %b want 1", in_ready); end
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstfull_no_ghost: got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_add_flags();
      test_and_retain();
      test_sub_zero();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_full();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100us");
      $fatal(1);
   end

endmodule
